// File: rtl/fifo_stream_checker.sv
// Passive FIFO stream monitor: beat counts, occupancy, per-side duplicate and
// sequence checks, overflow/underflow, and first-error capture.
module fifo_stream_checker #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CHECK_MODE = 0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              full_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_valid_i,
  input  logic              empty_i,
  output logic [CNT_W-1:0]  wr_count_o,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic [CNT_W-1:0]  level_o,
  output logic              dup_wr_o,
  output logic              dup_rd_o,
  output logic              seq_err_wr_o,
  output logic              seq_err_rd_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              error_sticky_o,
  output logic [5:0]        first_err_code_o,
  output logic [DATA_W-1:0] first_err_data_o,
  output logic [CNT_W-1:0]  first_err_index_o
);

  localparam bit       SEQ_EN  = (CHECK_MODE == 1);
  // Flag order {underflow, overflow, seq_rd, seq_wr, dup_rd, dup_wr}
  localparam bit [5:0] WR_MASK = 6'b010101;

  typedef struct packed {
    logic              s0_wr_en;
    logic              s0_full;
    logic [DATA_W-1:0] s0_wr_data;
    logic              s0_rd_en;
    logic              s0_empty;
    logic              s0_rd_valid;
    logic [DATA_W-1:0] s0_rd_data;
    logic              have_prev_wr;
    logic [DATA_W-1:0] prev_wr;
    logic              have_prev_rd;
    logic [DATA_W-1:0] prev_rd;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rd_count;
    logic [5:0]        s1_flags;
    logic [DATA_W-1:0] s1_wr_data;
    logic [CNT_W-1:0]  s1_wr_idx;
    logic [DATA_W-1:0] s1_rd_data;
    logic [CNT_W-1:0]  s1_rd_idx;
    logic [5:0]        pulse;
    logic              sticky;
    logic [5:0]        code;
    logic [DATA_W-1:0] err_data;
    logic [CNT_W-1:0]  err_idx;
  } state_t;

  state_t r_st;
  state_t w_nxt;

  logic              w_wr_beat, w_rd_beat, w_ovf, w_unf;
  logic              w_dup_wr, w_dup_rd, w_seq_wr, w_seq_rd;
  logic [DATA_W-1:0] w_prev_wr_inc, w_prev_rd_inc;
  logic [5:0]        w_flags;

  // Increment held in its own DATA_W net so the compare wraps modulo 2^DATA_W
  assign w_prev_wr_inc = r_st.prev_wr + DATA_W'(1);
  assign w_prev_rd_inc = r_st.prev_rd + DATA_W'(1);

  assign w_wr_beat = r_st.s0_wr_en & ~r_st.s0_full;
  assign w_ovf     = r_st.s0_wr_en &  r_st.s0_full;
  assign w_rd_beat = r_st.s0_rd_valid;
  assign w_unf     = r_st.s0_rd_en &  r_st.s0_empty;

  assign w_dup_wr = w_wr_beat & r_st.have_prev_wr & (r_st.s0_wr_data == r_st.prev_wr);
  assign w_dup_rd = w_rd_beat & r_st.have_prev_rd & (r_st.s0_rd_data == r_st.prev_rd);
  assign w_seq_wr = SEQ_EN & w_wr_beat & r_st.have_prev_wr & (r_st.s0_wr_data != w_prev_wr_inc);
  assign w_seq_rd = SEQ_EN & w_rd_beat & r_st.have_prev_rd & (r_st.s0_rd_data != w_prev_rd_inc);

  assign w_flags = {w_unf, w_ovf, w_seq_rd, w_seq_wr, w_dup_rd, w_dup_wr};

  always_comb begin
    w_nxt = r_st;

    w_nxt.s0_wr_en    = wr_en_i;
    w_nxt.s0_full     = full_i;
    w_nxt.s0_wr_data  = wr_data_i;
    w_nxt.s0_rd_en    = rd_en_i;
    w_nxt.s0_empty    = empty_i;
    w_nxt.s0_rd_valid = rd_valid_i;
    w_nxt.s0_rd_data  = rd_data_i;

    if (w_wr_beat) begin
      w_nxt.prev_wr      = r_st.s0_wr_data;
      w_nxt.have_prev_wr = 1'b1;
      w_nxt.wr_count     = r_st.wr_count + CNT_W'(1);
    end
    if (w_rd_beat) begin
      w_nxt.prev_rd      = r_st.s0_rd_data;
      w_nxt.have_prev_rd = 1'b1;
      w_nxt.rd_count     = r_st.rd_count + CNT_W'(1);
    end

    // Pre-increment counts double as the error index (overflow uses current wr_count)
    w_nxt.s1_flags   = w_flags;
    w_nxt.s1_wr_data = r_st.s0_wr_data;
    w_nxt.s1_wr_idx  = r_st.wr_count;
    w_nxt.s1_rd_data = r_st.s0_rd_data;
    w_nxt.s1_rd_idx  = r_st.rd_count;

    w_nxt.pulse = r_st.s1_flags;
    if (!r_st.sticky && (|r_st.s1_flags)) begin
      w_nxt.sticky = 1'b1;
      w_nxt.code   = r_st.s1_flags;
      if (|(r_st.s1_flags & WR_MASK)) begin
        w_nxt.err_data = r_st.s1_wr_data;
        w_nxt.err_idx  = r_st.s1_wr_idx;
      end else begin
        w_nxt.err_data = r_st.s1_rd_data;
        w_nxt.err_idx  = r_st.s1_rd_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_st <= '0;
    end else if (clear_i) begin
      r_st <= '0;
    end else begin
      r_st <= w_nxt;
    end
  end

  assign wr_count_o        = r_st.wr_count;
  assign rd_count_o        = r_st.rd_count;
  assign level_o           = r_st.wr_count - r_st.rd_count;
  assign dup_wr_o          = r_st.pulse[0];
  assign dup_rd_o          = r_st.pulse[1];
  assign seq_err_wr_o      = r_st.pulse[2];
  assign seq_err_rd_o      = r_st.pulse[3];
  assign overflow_o        = r_st.pulse[4];
  assign underflow_o       = r_st.pulse[5];
  assign error_sticky_o    = r_st.sticky;
  assign first_err_code_o  = r_st.code;
  assign first_err_data_o  = r_st.err_data;
  assign first_err_index_o = r_st.err_idx;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Bench for fifo_stream_checker: two instances (CNT_W=4 with sequence check,
// CNT_W=16 duplicate-only) share stimulus and are scored against an event model.
module tb_fifo_stream_checker;

  localparam int DW  = 8;
  localparam int NEX = 8192;

  typedef struct packed {
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] level;
    logic [5:0]  pulse;
    logic        sticky;
    logic [5:0]  code;
    logic [7:0]  data;
    logic [15:0] idx;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0, wr_en = 1'b0, full = 1'b0;
  logic          rd_en = 1'b0, rd_valid = 1'b0, empty = 1'b0;
  logic [DW-1:0] wr_data = '0, rd_data = '0;

  always #5 clk = ~clk;

  logic [3:0]    a_wc, a_rc, a_lvl, a_idx;
  logic          a_dw, a_dr, a_sw, a_sr, a_ov, a_un, a_stk;
  logic [5:0]    a_code;
  logic [DW-1:0] a_data;
  logic [15:0]   b_wc, b_rc, b_lvl, b_idx;
  logic          b_dw, b_dr, b_sw, b_sr, b_ov, b_un, b_stk;
  logic [5:0]    b_code;
  logic [DW-1:0] b_data;

  fifo_stream_checker #(.DATA_W(DW), .CNT_W(4), .CHECK_MODE(1)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .full_i(full),
    .rd_en_i(rd_en), .rd_data_i(rd_data), .rd_valid_i(rd_valid), .empty_i(empty),
    .wr_count_o(a_wc), .rd_count_o(a_rc), .level_o(a_lvl),
    .dup_wr_o(a_dw), .dup_rd_o(a_dr), .seq_err_wr_o(a_sw), .seq_err_rd_o(a_sr),
    .overflow_o(a_ov), .underflow_o(a_un), .error_sticky_o(a_stk),
    .first_err_code_o(a_code), .first_err_data_o(a_data), .first_err_index_o(a_idx)
  );

  fifo_stream_checker #(.DATA_W(DW), .CNT_W(16), .CHECK_MODE(0)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .full_i(full),
    .rd_en_i(rd_en), .rd_data_i(rd_data), .rd_valid_i(rd_valid), .empty_i(empty),
    .wr_count_o(b_wc), .rd_count_o(b_rc), .level_o(b_lvl),
    .dup_wr_o(b_dw), .dup_rd_o(b_dr), .seq_err_wr_o(b_sw), .seq_err_rd_o(b_sr),
    .overflow_o(b_ov), .underflow_o(b_un), .error_sticky_o(b_stk),
    .first_err_code_o(b_code), .first_err_data_o(b_data), .first_err_index_o(b_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  // Reference model state, index 0 = u_a, index 1 = u_b
  int unsigned m_mask [2] = '{32'h0000_000F, 32'h0000_FFFF};
  bit          m_mode [2] = '{1'b1, 1'b0};
  int unsigned m_wc [2], m_rc [2], m_eidx [2];
  bit          m_hw [2], m_hr [2], m_stk [2];
  logic [7:0]  m_pw [2], m_pr [2], m_edata [2];
  logic [5:0]  m_code [2];
  obs_t        ex [2][NEX];
  obs_t        q [2][$];

  function automatic obs_t get_obs(input int m);
    obs_t o;
    if (m == 0) begin
      o.wr_cnt = {12'd0, a_wc}; o.rd_cnt = {12'd0, a_rc}; o.level = {12'd0, a_lvl};
      o.pulse  = {a_un, a_ov, a_sr, a_sw, a_dr, a_dw};
      o.sticky = a_stk; o.code = a_code; o.data = a_data; o.idx = {12'd0, a_idx};
    end else begin
      o.wr_cnt = b_wc; o.rd_cnt = b_rc; o.level = b_lvl;
      o.pulse  = {b_un, b_ov, b_sr, b_sw, b_dr, b_dw};
      o.sticky = b_stk; o.code = b_code; o.data = b_data; o.idx = b_idx;
    end
    return o;
  endfunction

  task automatic cmp(input string nm, input int m, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, m, cyc, got, exp);
    end
  endtask

  task automatic check_obs(input string tag, input int m, input obs_t a, input obs_t e);
    cmp({tag, "_counts"}, m, {32'd0, a.wr_cnt, a.rd_cnt}, {32'd0, e.wr_cnt, e.rd_cnt});
    cmp({tag, "_level"},  m, {48'd0, a.level}, {48'd0, e.level});
    cmp({tag, "_pulse"},  m, {58'd0, a.pulse}, {58'd0, e.pulse});
    cmp({tag, "_capture"}, m, {33'd0, a.sticky, a.code, a.data, a.idx},
                              {33'd0, e.sticky, e.code, e.data, e.idx});
  endtask

  task automatic model_zero();
    obs_t z;
    z = '0;
    for (int m = 0; m < 2; m++) begin
      m_wc[m] = 0; m_rc[m] = 0; m_hw[m] = 1'b0; m_hr[m] = 1'b0;
      m_pw[m] = '0; m_pr[m] = '0;
      m_stk[m] = 1'b0; m_code[m] = '0; m_edata[m] = '0; m_eidx[m] = 0;
    end
    for (int i = 0; i < NEX; i++) begin
      ex[0][i] = z;
      ex[1][i] = z;
    end
  endtask

  // Turns the inputs about to be sampled at edge k into an event, places its
  // count effect one edge later and its pulses/capture two edges later.
  task automatic model_step(input int k);
    obs_t       z;
    bit         wb, rb, ovf, unf, dwr, drd, swr, srd;
    logic [7:0] nw, nr;
    logic [5:0] fl;
    z = '0;
    for (int m = 0; m < 2; m++) begin
      if (clr) begin
        m_wc[m] = 0; m_rc[m] = 0; m_hw[m] = 1'b0; m_hr[m] = 1'b0;
        m_stk[m] = 1'b0; m_code[m] = '0; m_edata[m] = '0; m_eidx[m] = 0;
        ex[m][k] = z; ex[m][k+1] = z; ex[m][k+2] = z;
      end else begin
        wb  = wr_en && !full;
        ovf = wr_en && full;
        rb  = rd_valid;
        unf = rd_en && empty;
        nw  = m_pw[m] + 8'd1;
        nr  = m_pr[m] + 8'd1;
        dwr = wb && m_hw[m] && (wr_data == m_pw[m]);
        drd = rb && m_hr[m] && (rd_data == m_pr[m]);
        swr = m_mode[m] && wb && m_hw[m] && (wr_data != nw);
        srd = m_mode[m] && rb && m_hr[m] && (rd_data != nr);
        fl  = {unf, ovf, srd, swr, drd, dwr};
        if (!m_stk[m] && fl != 6'd0) begin
          m_stk[m]  = 1'b1;
          m_code[m] = fl;
          if (dwr || swr || ovf) begin
            m_edata[m] = wr_data; m_eidx[m] = m_wc[m];
          end else begin
            m_edata[m] = rd_data; m_eidx[m] = m_rc[m];
          end
        end
        if (wb) begin
          m_pw[m] = wr_data; m_hw[m] = 1'b1; m_wc[m] = (m_wc[m] + 1) & m_mask[m];
        end
        if (rb) begin
          m_pr[m] = rd_data; m_hr[m] = 1'b1; m_rc[m] = (m_rc[m] + 1) & m_mask[m];
        end
        ex[m][k+1].wr_cnt = 16'(m_wc[m]);
        ex[m][k+1].rd_cnt = 16'(m_rc[m]);
        ex[m][k+1].level  = 16'((m_wc[m] - m_rc[m]) & m_mask[m]);
        ex[m][k+2].pulse  = fl;
        ex[m][k+2].sticky = m_stk[m];
        ex[m][k+2].code   = m_code[m];
        ex[m][k+2].data   = m_edata[m];
        ex[m][k+2].idx    = 16'(m_eidx[m]);
      end
      q[m].push_back(ex[m][k]);
    end
  endtask

  // Scoreboard monitor: one expected record per DUT per monitored edge
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        if (q[m].size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underrun dut%0d cyc=%0d got=empty exp=record", m, cyc);
        end else begin
          check_obs("sb", m, get_obs(m), q[m].pop_front());
        end
      end
    end
  end

  task automatic step(input logic we, input logic [7:0] wd, input logic fl,
                      input logic rv, input logic [7:0] rdd, input logic re,
                      input logic em, input logic cl);
    @(negedge clk);
    wr_en = we; wr_data = wd; full = fl;
    rd_valid = rv; rd_data = rdd; rd_en = re; empty = em; clr = cl;
    model_step(cyc);
    cyc++;
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) check_obs("rst_async", m, get_obs(m), '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en = $urandom_range(0, 1); full = $urandom_range(0, 1);
      wr_data = 8'($urandom); rd_data = 8'($urandom);
      rd_valid = $urandom_range(0, 1); rd_en = $urandom_range(0, 1); empty = $urandom_range(0, 1);
      #1;
      for (int m = 0; m < 2; m++) check_obs("rst_hold", m, get_obs(m), '0);
    end
    @(negedge clk);
    wr_en = 1'b0; full = 1'b0; rd_valid = 1'b0; rd_en = 1'b0; empty = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    q[0].delete(); q[1].delete();
    model_zero();
  endtask

  task automatic rand_run(input int n);
    logic [7:0] lw, lr, d;
    int         r;
    lw = '0; lr = '0;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      d = (r < 60) ? lw + 8'd1 : (r < 75) ? lw : 8'($urandom);
      lw = d;
      r = $urandom_range(0, 99);
      lr = (r < 60) ? lr + 8'd1 : (r < 75) ? lr : 8'($urandom);
      step($urandom_range(0, 1) == 1, d, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, lr, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
    end
  endtask

  initial begin
    model_zero();
    do_reset();
    idle(3);

    // Clean incrementing writes then matching reads
    step(1, 8'd1, 0, 0, 8'd0, 0, 0, 0);
    step(1, 8'd2, 0, 0, 8'd0, 0, 0, 0);
    step(1, 8'd3, 0, 0, 8'd0, 0, 0, 0);
    idle(3);
    step(0, 8'd0, 0, 1, 8'd1, 1, 0, 0);
    step(0, 8'd0, 0, 1, 8'd2, 1, 0, 0);
    step(0, 8'd0, 0, 1, 8'd3, 1, 0, 0);
    idle(3);

    // Write duplicate, then a later read duplicate that must not recapture
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, 1);
    step(1, 8'd5, 0, 0, 8'd0, 0, 0, 0);
    step(1, 8'd5, 0, 0, 8'd0, 0, 0, 0);
    idle(3);
    step(0, 8'd0, 0, 1, 8'd9, 0, 0, 0);
    step(0, 8'd0, 0, 1, 8'd9, 0, 0, 0);
    idle(3);

    // Read sequence break coinciding with an overflow
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, 1);
    step(0, 8'd0, 0, 1, 8'd0, 0, 0, 0);
    step(0, 8'd0, 0, 1, 8'd1, 0, 0, 0);
    step(1, 8'hAA, 1, 1, 8'd3, 0, 0, 0);
    idle(3);

    // Underflow alone captures from the read side
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, 1);
    step(0, 8'd0, 0, 0, 8'h3C, 1, 1, 0);
    idle(3);

    // 17 writes: CNT_W=4 instance wraps to 1
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0, 8'd0, 0, 0, 0);
    idle(3);

    // Clear between identical words: no duplicate, counts restart
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, 1);
    step(1, 8'd7, 0, 0, 8'd0, 0, 0, 0);
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, 1);
    step(1, 8'd7, 0, 0, 8'd0, 0, 0, 0);
    idle(3);

    // Clear landing on an in-flight duplicate
    step(1, 8'd8, 0, 0, 8'd0, 0, 0, 0);
    step(1, 8'd8, 0, 0, 8'd0, 0, 0, 0);
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, 1);
    idle(4);

    rand_run(2000);
    do_reset();
    idle(2);
    rand_run(300);
    idle(3);

    @(posedge clk);
    #3 mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
